bsg_nor2_bist: RTL
==================

# bsg_nor2_bist

Built-in self-test engine for a `bsg_nor2` bank. It sits at the opposite end of the bank's interface. It drives the bank's `a_i`/`b_i` operands, receives the bank's `o` result back, and compares each result against an internally computed `~(a|b)`. It runs a directed-plus-pseudorandom pattern sequence, tolerates a configurable DUT pipeline latency, and reports pass/fail with a saturating error count. It is used at bring-up and in the regression harness for every NOR bank instance.

## Interface
- `width_p`, 128, operand/result width; any value ≥ 1.
- `num_random_p`, 16, number of LFSR patterns after the directed ones; ≥ 0.
- `dut_latency_p`, 0, DUT cycles from operand to result; 0..3.
- `seed_p`, 32'h1, LFSR seed; must be nonzero.
- `clk_i` in 1: single clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: start request; sampled in IDLE or DONE.
- `a_o` out `width_p`: operand A to DUT; registered.
- `b_o` out `width_p`: operand B to DUT; registered.
- `o_i` in `width_p`: DUT result.
- `busy_o` out 1: sequence in progress.
- `done_o` out 1: sequence complete; results valid.
- `pass_o` out 1: no mismatches; valid only while `done_o`=1.
- `err_count_o` out 16: mismatching patterns; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN on `start_i`. DONE→RUN on `start_i`; this clears the error count and reloads the LFSR.
- RUN: one pattern per cycle, indexed by a pattern counter. Total patterns NPAT = 4 + `num_random_p`.
  - Index 0: a=0, b=0, expect all-ones.
  - Index 1: a=all-ones, b=0.
  - Index 2: a=0, b=all-ones.
  - Index 3: both all-ones.
  - Index ≥ 4: a = 32-bit LFSR state replicated/truncated to `width_p`; b = same LFSR rotated left by 16, replicated.
  - The LFSR advances once per random pattern.
- LFSR: Fibonacci, polynomial x^32+x^22+x^2+x+1, shifts left; loaded with `seed_p` at start.
- Expected value `~(a_o|b_o)` and a valid bit travel through a `dut_latency_p`-deep delay line.
  - When the delayed valid is set, compare against `o_i`.
  - Any bit differing counts as one error for that pattern, not one per bit.
- After the last pattern, RUN→DRAIN. DRAIN waits for the delay line to empty; with latency 0 it lasts 0 cycles and the FSM goes straight to DONE.
- DONE: holds the results; `a_o`/`b_o` return to 0.
- `start_i` in RUN or DRAIN is ignored.
- Reset in any state aborts to IDLE immediately.
- Reset values:
  - `a_o`=0, `b_o`=0.
  - `busy_o`=0, `done_o`=0, `pass_o`=0.
  - `err_count_o`=0.
  - LFSR=`seed_p`, delay line cleared.

## Timing
- Cycle after `start_i` is sampled: `busy_o`=1 and pattern 0 appears on `a_o`/`b_o`.
- Pattern k is launched at cycle k of RUN.
- `o_i` for pattern k is sampled `dut_latency_p` cycles after launch. With latency 0, it is sampled in the same cycle (combinational DUT).
- `busy_o` stays high for exactly NPAT + `dut_latency_p` cycles.
- `done_o` rises the cycle after the final compare. `pass_o` = (`err_count_o`==0) in that same cycle.
- The error-count update for a compare is visible on the next cycle.
- Saturation: an increment at 16'hFFFF leaves it at 16'hFFFF.

## Configuration
- `BSG_NOR2_BIST_FIRST_FAIL_EN` defined:
  - Adds outputs `first_fail_idx_o` (16 bits) and `first_fail_mask_o` (`width_p` bits), reset to 0.
  - On the first mismatch after start, they capture the pattern index and `o_i ^ expected`.
  - Later mismatches do not overwrite them; they are cleared on start.
- Not defined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Package `bsg_nor2_bist_pkg`:
  - FSM state enum.
  - Directed-pattern count constant (4).
  - LFSR polynomial/tap constant.
  - Error-count width (16).
- Sub-module `bsg_nor2_bist_lfsr`: 32-bit LFSR with load, enable and seed parameter.
- Delay line, compare and FSM live in the top block.

## Test plan
- Ideal `bsg_nor2` DUT, `width_p`=128, latency 0, `num_random_p`=16, pulse `start_i` → `busy_o` high 20 cycles, then `done_o`=1, `pass_o`=1, `err_count_o`=0.
- DUT output fully inverted (`o_i`=a|b), same config → `err_count_o`=20, `pass_o`=0. With FIRST_FAIL_EN: idx=0, mask=all-ones.
- Ideal DUT behind 3 register stages, `dut_latency_p`=3 → `busy_o` high 23 cycles, `pass_o`=1. Same DUT with `dut_latency_p`=2 → `pass_o`=0.
- `o_i[5]` stuck at 0, `num_random_p`=0 → `err_count_o`=1 (index 0 only). With FIRST_FAIL_EN: mask=1<<5.
- Inverted DUT, `num_random_p`=70000 → `err_count_o`=16'hFFFF at done.
- Assert `reset_i` mid-RUN → all outputs 0 next edge. `start_i` pulsed during RUN → no restart, cycle count unchanged. Restart from DONE → error count cleared and identical pattern sequence repeated.

Source files
------------

// File: rtl/bsg_nor2_bist_pkg.sv
// Shared types and constants for the bsg_nor2 bank self-test engine.
package bsg_nor2_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } bist_state_e;

  localparam int unsigned NumDirected = 4;

  // x^32 + x^22 + x^2 + x + 1, as feedback taps on state bits 31, 21, 1 and 0
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  localparam int unsigned ErrCntW = 16;

endpackage

// File: rtl/bsg_nor2_bist_lfsr.sv
// 32-bit left-shifting Fibonacci LFSR with synchronous seed load and step enable.
module bsg_nor2_bist_lfsr
  import bsg_nor2_bist_pkg::*;
#(
  parameter logic [31:0] seed_p = 32'h1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        en_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_p;
    end else if (en_i) begin
      state_d = {state_q[30:0], ^(state_q & LfsrTaps)};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= seed_p;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/bsg_nor2_bist.sv
// BIST engine for a bsg_nor2 bank: drives operands, checks ~(a|b) after a fixed latency.
// Define BSG_NOR2_BIST_FIRST_FAIL_EN to add first-failure index/mask capture ports.
module bsg_nor2_bist
  import bsg_nor2_bist_pkg::*;
#(
  parameter int unsigned width_p       = 128,
  parameter int unsigned num_random_p  = 16,
  parameter int unsigned dut_latency_p = 0,
  parameter logic [31:0] seed_p        = 32'h1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic [width_p-1:0] a_o,
  output logic [width_p-1:0] b_o,
  input  logic [width_p-1:0] o_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [ErrCntW-1:0] err_count_o
`ifdef BSG_NOR2_BIST_FIRST_FAIL_EN
  ,
  output logic [15:0]        first_fail_idx_o,
  output logic [width_p-1:0] first_fail_mask_o
`endif
);

  localparam int unsigned NumPat  = NumDirected + num_random_p;
  localparam logic [31:0] LastIdx = 32'(NumPat - 1);

  bist_state_e        state_q, state_d;
  logic [31:0]        idx_q, idx_d, nxt_idx;
  logic [width_p-1:0] a_q, a_d, b_q, b_d;
  logic [width_p-1:0] nxt_a, nxt_b, rnd_a, rnd_b;
  logic [1:0]         drain_q, drain_d;
  logic [ErrCntW-1:0] err_q, err_d;
  logic               lfsr_load, lfsr_en, start_run;
  logic [31:0]        lfsr_state, lfsr_rot;
  logic               launch_vld, cmp_vld, mismatch;
  logic [width_p-1:0] launch_exp, cmp_exp;

  bsg_nor2_bist_lfsr #(
    .seed_p (seed_p)
  ) u_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (lfsr_load),
    .en_i    (lfsr_en),
    .state_o (lfsr_state)
  );

  assign lfsr_rot = {lfsr_state[15:0], lfsr_state[31:16]};
  // Index of the pattern that would be registered onto a_o/b_o this cycle
  assign nxt_idx  = (state_q == StRun) ? idx_q + 32'd1 : '0;

  always_comb begin
    rnd_a = '0;
    rnd_b = '0;
    for (int i = 0; i < int'(width_p); i++) begin
      rnd_a[i] = lfsr_state[i % 32];
      rnd_b[i] = lfsr_rot[i % 32];
    end
    if (nxt_idx == 32'd0) begin
      nxt_a = '0;
      nxt_b = '0;
    end else if (nxt_idx == 32'd1) begin
      nxt_a = '1;
      nxt_b = '0;
    end else if (nxt_idx == 32'd2) begin
      nxt_a = '0;
      nxt_b = '1;
    end else if (nxt_idx == 32'd3) begin
      nxt_a = '1;
      nxt_b = '1;
    end else begin
      nxt_a = rnd_a;
      nxt_b = rnd_b;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    drain_d   = drain_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    start_run = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StRun;
          idx_d     = '0;
          a_d       = nxt_a;
          b_d       = nxt_b;
          lfsr_load = 1'b1;
          start_run = 1'b1;
        end
      end
      StRun: begin
        if (idx_q == LastIdx) begin
          a_d = '0;
          b_d = '0;
          if (dut_latency_p == 0) begin
            state_d = StDone;
          end else begin
            state_d = StDrain;
            drain_d = 2'(dut_latency_p - 1);
          end
        end else begin
          idx_d   = nxt_idx;
          a_d     = nxt_a;
          b_d     = nxt_b;
          lfsr_en = (nxt_idx >= NumDirected);
        end
      end
      StDrain: begin
        if (drain_q == 2'd0) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign launch_vld = (state_q == StRun);
  assign launch_exp = ~(a_q | b_q);

  if (dut_latency_p == 0) begin : g_no_dly
    assign cmp_vld = launch_vld;
    assign cmp_exp = launch_exp;
  end else begin : g_dly
    logic [dut_latency_p-1:0] vld_q;
    logic [width_p-1:0]       exp_q [dut_latency_p];

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        vld_q <= '0;
        for (int i = 0; i < int'(dut_latency_p); i++) exp_q[i] <= '0;
      end else begin
        vld_q[0] <= launch_vld;
        exp_q[0] <= launch_exp;
        for (int i = 1; i < int'(dut_latency_p); i++) begin
          vld_q[i] <= vld_q[i-1];
          exp_q[i] <= exp_q[i-1];
        end
      end
    end

    assign cmp_vld = vld_q[dut_latency_p-1];
    assign cmp_exp = exp_q[dut_latency_p-1];
  end

  // One error per mismatching pattern regardless of how many bits differ
  assign mismatch = cmp_vld && (o_i != cmp_exp);

  always_comb begin
    err_d = err_q;
    if (start_run) begin
      err_d = '0;
    end else if (mismatch && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      drain_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

`ifdef BSG_NOR2_BIST_FIRST_FAIL_EN
  logic [15:0]        cmp_idx_q, ff_idx_q;
  logic [width_p-1:0] ff_mask_q;
  logic               ff_seen_q;

  // Compares retire in launch order, so a running count recovers the pattern index
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmp_idx_q <= '0;
      ff_idx_q  <= '0;
      ff_mask_q <= '0;
      ff_seen_q <= 1'b0;
    end else if (start_run) begin
      cmp_idx_q <= '0;
      ff_idx_q  <= '0;
      ff_mask_q <= '0;
      ff_seen_q <= 1'b0;
    end else if (cmp_vld) begin
      cmp_idx_q <= cmp_idx_q + 16'd1;
      if (mismatch && !ff_seen_q) begin
        ff_seen_q <= 1'b1;
        ff_idx_q  <= cmp_idx_q;
        ff_mask_q <= o_i ^ cmp_exp;
      end
    end
  end

  assign first_fail_idx_o  = ff_idx_q;
  assign first_fail_mask_o = ff_mask_q;
`endif

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign busy_o      = (state_q == StRun) || (state_q == StDrain);
  assign done_o      = (state_q == StDone);
  assign pass_o      = (state_q == StDone) && (err_q == '0);
  assign err_count_o = err_q;

endmodule
